// File: rtl/ddr3_ba_lane_ctrl_if.sv
// Bundle between the DDR controller, the BA lane controller and the BA IOD wrapper.
//   dfi_ba_p[k]        : bank address for TX phase k (one bit per lane)
//   dfi_cmd_valid      : phase BA values valid this cycle
//   out_en             : pin drive enable
//   tx_data/oe_data    : per-lane 4-phase serialiser words (bit k = phase k)
//   adj_*              : delay adjustment request / status, tap_cnt read-back
//   delay_line_*       : per-lane dynamic delay-line controls and range flag
interface ddr3_ba_lane_ctrl_if #(
  parameter int unsigned NUM_LANES = 3,
  parameter int unsigned PHASES    = 4
);
  logic [PHASES-1:0][NUM_LANES-1:0] dfi_ba_p;
  logic                             dfi_cmd_valid;
  logic                             out_en;
  logic [NUM_LANES-1:0][PHASES-1:0] tx_data;
  logic [NUM_LANES-1:0][PHASES-1:0] oe_data;

  logic                             adj_req;
  logic [1:0]                       adj_lane;
  logic                             adj_dir;
  logic [7:0]                       adj_steps;
  logic                             adj_load;
  logic                             adj_busy;
  logic                             adj_done;
  logic                             adj_err;
  logic [7:0]                       tap_cnt;

  logic [NUM_LANES-1:0]             delay_line_move;
  logic [NUM_LANES-1:0]             delay_line_direction;
  logic [NUM_LANES-1:0]             delay_line_load;
  logic [NUM_LANES-1:0]             delay_line_out_of_range;

  // Environment side: controller command path plus the IOD range flags
  modport master (
    output dfi_ba_p, dfi_cmd_valid, out_en,
    output adj_req, adj_lane, adj_dir, adj_steps, adj_load,
    output delay_line_out_of_range,
    input  tx_data, oe_data, adj_busy, adj_done, adj_err, tap_cnt,
    input  delay_line_move, delay_line_direction, delay_line_load
  );

  // Lane controller side
  modport slave (
    input  dfi_ba_p, dfi_cmd_valid, out_en,
    input  adj_req, adj_lane, adj_dir, adj_steps, adj_load,
    input  delay_line_out_of_range,
    output tx_data, oe_data, adj_busy, adj_done, adj_err, tap_cnt,
    output delay_line_move, delay_line_direction, delay_line_load
  );
endinterface

// File: rtl/ddr3_ba_lane_ctrl.sv
// DDR3 bank-address lane controller (FAB_CLK domain).
// Packs per-phase DFI bank addresses into per-lane 4:1 TX/OE words and
// sequences the BA IOD dynamic delay lines (load / move / direction) for
// training, tracking a per-lane tap count.
//   i_fab_clk : fabric clock, rising edge
//   i_arst    : asynchronous active-high reset (shared with the IOD)
//   io_bus    : ddr3_ba_lane_ctrl_if.slave (DFI inputs, TX/OE words,
//               adjustment request/status, delay-line controls)
module ddr3_ba_lane_ctrl #(
  parameter int unsigned NUM_LANES = 3,
  parameter int unsigned PHASES    = 4,
  parameter int unsigned INIT_TAP  = 1,
  parameter int unsigned MAX_TAP   = 127,
  parameter int unsigned MOVE_GAP  = 3
) (
  input  logic                      i_fab_clk,
  input  logic                      i_arst,
  ddr3_ba_lane_ctrl_if.slave        io_bus
);

  localparam int unsigned TAP_W  = 8;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned GAP_W  = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NUM_LANES - 1);
  localparam logic [TAP_W-1:0]  INIT_TAP_V = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0]  MAX_TAP_V  = TAP_W'(MAX_TAP);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(MOVE_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MOVE,
    ST_GAP,
    ST_CHECK,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------- data path
  logic [NUM_LANES-1:0][PHASES-1:0] r_tx_data;
  logic [NUM_LANES-1:0][PHASES-1:0] r_oe_data;
  logic [NUM_LANES-1:0][PHASES-1:0] w_tx_next;

  // Transpose phase-major DFI bits into lane-major serialiser words
  always_comb begin
    w_tx_next = '0;
    for (int unsigned n = 0; n < NUM_LANES; n++) begin
      for (int unsigned k = 0; k < PHASES; k++) begin
        w_tx_next[n][k] = io_bus.dfi_ba_p[k][n];
      end
    end
  end

  // TX holds between commands so idle BA pins do not toggle
  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) begin
      r_tx_data <= '0;
      r_oe_data <= '0;
    end else begin
      if (io_bus.dfi_cmd_valid) begin
        r_tx_data <= w_tx_next;
      end
      r_oe_data <= {(NUM_LANES * PHASES){io_bus.out_en}};
    end
  end

  // ------------------------------------------------------- delay adjustment
  state_t                           r_state;
  state_t                           w_next;
  logic [LANE_W-1:0]                r_lane;
  logic                             r_dir;
  logic [STEP_W-1:0]                r_steps;
  logic [GAP_W-1:0]                 r_gap_cnt;
  logic [NUM_LANES-1:0][TAP_W-1:0]  r_tap;
  logic [NUM_LANES-1:0]             r_move;
  logic [NUM_LANES-1:0]             r_load;
  logic [NUM_LANES-1:0]             r_dir_out;
  logic                             r_busy;
  logic                             r_done;
  logic                             r_err;

  logic [LANE_W-1:0]                w_sel_lane;
  logic                             w_sel_dir;
  logic [TAP_W-1:0]                 w_cur_tap;
  logic [TAP_W-1:0]                 w_eff_tap;
  logic [TAP_W-1:0]                 w_tap_rd;
  logic                             w_oor;
  logic                             w_step_ok;
  logic                             w_capture;
  logic                             w_err_set;

  // Lane/direction in effect: request inputs while idle, captured copy afterwards.
  // In LOAD the counter is about to become INIT_TAP, so the range check uses that.
  always_comb begin
    w_sel_lane = (r_state == ST_IDLE) ? io_bus.adj_lane : r_lane;
    w_sel_dir  = (r_state == ST_IDLE) ? io_bus.adj_dir  : r_dir;
    w_cur_tap  = '0;
    w_oor      = 1'b0;
    w_tap_rd   = '0;
    for (int unsigned n = 0; n < NUM_LANES; n++) begin
      if (w_sel_lane == LANE_W'(n))       w_cur_tap = r_tap[n];
      if (r_lane == LANE_W'(n))           w_oor     = io_bus.delay_line_out_of_range[n];
      if (io_bus.adj_lane == LANE_W'(n))  w_tap_rd  = r_tap[n];
    end
    w_eff_tap = (r_state == ST_LOAD) ? INIT_TAP_V : w_cur_tap;
    w_step_ok = w_sel_dir ? (w_eff_tap < MAX_TAP_V) : (w_eff_tap != '0);
  end

  // State register
  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state; a step that would leave the legal tap range ends with an error
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.adj_req) begin
          w_capture = 1'b1;
          if (io_bus.adj_lane > LAST_LANE) begin
            w_next    = ST_DONE;
            w_err_set = 1'b1;
          end else if (io_bus.adj_load) begin
            w_next = ST_LOAD;
          end else if (io_bus.adj_steps == '0) begin
            w_next = ST_DONE;
          end else if (!w_step_ok) begin
            w_next    = ST_DONE;
            w_err_set = 1'b1;
          end else begin
            w_next = ST_MOVE;
          end
        end
      end
      ST_LOAD: begin
        if (r_steps == '0) begin
          w_next = ST_DONE;
        end else if (!w_step_ok) begin
          w_next    = ST_DONE;
          w_err_set = 1'b1;
        end else begin
          w_next = ST_MOVE;
        end
      end
      ST_MOVE: begin
        w_next = (MOVE_GAP == 0) ? ST_CHECK : ST_GAP;
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_oor) begin
          w_next    = ST_DONE;
          w_err_set = 1'b1;
        end else if (r_steps == '0) begin
          w_next = ST_DONE;
        end else if (!w_step_ok) begin
          w_next    = ST_DONE;
          w_err_set = 1'b1;
        end else begin
          w_next = ST_MOVE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request capture, tap tracking and registered IOD controls.
  // Controls are decoded from the next state so they line up with LOAD/MOVE.
  always_ff @(posedge i_fab_clk or posedge i_arst) begin
    if (i_arst) begin
      r_lane    <= '0;
      r_dir     <= 1'b0;
      r_steps   <= '0;
      r_gap_cnt <= '0;
      r_tap     <= {NUM_LANES{INIT_TAP_V}};
      r_move    <= '0;
      r_load    <= '0;
      r_dir_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_lane  <= io_bus.adj_lane;
        r_dir   <= io_bus.adj_dir;
        r_steps <= io_bus.adj_steps;
        r_err   <= 1'b0;
      end
      if (w_err_set) r_err <= 1'b1;

      if (r_state == ST_MOVE) r_steps <= r_steps - STEP_W'(1);

      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GAP_W'(1) : '0;

      for (int unsigned n = 0; n < NUM_LANES; n++) begin
        if (r_lane == LANE_W'(n)) begin
          if (r_state == ST_LOAD) begin
            r_tap[n] <= INIT_TAP_V;
          end else if (r_state == ST_MOVE) begin
            r_tap[n] <= r_dir ? r_tap[n] + TAP_W'(1) : r_tap[n] - TAP_W'(1);
          end
        end
        r_move[n] <= (w_sel_lane == LANE_W'(n)) && (w_next == ST_MOVE);
        r_load[n] <= (w_sel_lane == LANE_W'(n)) && (w_next == ST_LOAD);
        if ((w_sel_lane == LANE_W'(n)) && (w_next == ST_MOVE)) begin
          r_dir_out[n] <= w_sel_dir;
        end
      end

      r_busy <= (w_next inside {ST_LOAD, ST_MOVE, ST_GAP, ST_CHECK});
      r_done <= (w_next == ST_DONE);
    end
  end

  assign io_bus.tx_data              = r_tx_data;
  assign io_bus.oe_data              = r_oe_data;
  assign io_bus.delay_line_move      = r_move;
  assign io_bus.delay_line_load      = r_load;
  assign io_bus.delay_line_direction = r_dir_out;
  assign io_bus.adj_busy             = r_busy;
  assign io_bus.adj_done             = r_done;
  assign io_bus.adj_err              = r_err;
  assign io_bus.tap_cnt              = w_tap_rd;

endmodule
